cnu_serial: RTL and testbench

CNU_SERIAL -- requirements
Module: cnu_serial

---
 rtl/cnu_serial.sv | 139 +++++++++++++
 tb/tb_cnu_serial.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cnu_serial.sv
// Serial min-sum check-node unit: collects DC messages, then emits DC replies.
// Define CNU_OFFSET_EN to subtract OFFSET from emitted magnitudes (offset min-sum).
module cnu_serial #(
   parameter int DC     = 6,
   parameter int W      = 6,
   parameter int OW     = 5,
   parameter int OFFSET = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_msg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OW-1:0]         out_msg,
   output logic [$clog2(DC)-1:0] out_idx,
   output logic                  out_last,
   output logic                  p_bit
);

   localparam int CW = $clog2(DC);
   localparam int MW = W - 1;
   localparam logic [CW-1:0] LAST = CW'(DC - 1);
   localparam logic [MW-1:0] SATV = MW'((1 << (OW - 1)) - 1);

   typedef enum logic {
      COLLECT,
      EMIT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [CW-1:0]   idx1_q,  idx1_d;
   logic [MW-1:0]   min1_q,  min1_d;
   logic [MW-1:0]   min2_q,  min2_d;
   logic            sx_q,    sx_d;
   logic [DC-1:0]   sign_q,  sign_d;
   logic            pbit_q,  pbit_d;

   logic [MW-1:0]   in_mag;
   logic            in_sgn;
   logic [MW-1:0]   mag_sel;
   logic [MW-1:0]   mag_off;
   logic [OW-2:0]   mag_sat;

   assign in_mag = in_msg[MW-1:0];
   assign in_sgn = in_msg[W-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx1_d  = idx1_q;
      min1_d  = min1_q;
      min2_d  = min2_q;
      sx_d    = sx_q;
      sign_d  = sign_q;
      pbit_d  = pbit_q;
      unique case (state_q)
         COLLECT: begin
            if (in_valid) begin
               sign_d[cnt_q] = in_sgn;
               sx_d          = sx_q ^ in_sgn;
               // strict compare keeps idx1 on the first of equal minima
               if (in_mag < min1_q) begin
                  min2_d = min1_q;
                  min1_d = in_mag;
                  idx1_d = cnt_q;
               end else if (in_mag < min2_q) begin
                  min2_d = in_mag;
               end
               if (cnt_q == LAST) begin
                  state_d = EMIT;
                  cnt_d   = '0;
                  pbit_d  = sx_q ^ in_sgn;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (cnt_q == LAST) begin
                  state_d = COLLECT;
                  cnt_d   = '0;
                  idx1_d  = '0;
                  min1_d  = '1;
                  min2_d  = '1;
                  sx_d    = 1'b0;
                  sign_d  = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         idx1_q  <= '0;
         min1_q  <= '1;
         min2_q  <= '1;
         sx_q    <= 1'b0;
         sign_q  <= '0;
         pbit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx1_q  <= idx1_d;
         min1_q  <= min1_d;
         min2_q  <= min2_d;
         sx_q    <= sx_d;
         sign_q  <= sign_d;
         pbit_q  <= pbit_d;
      end
   end

   assign mag_sel = (cnt_q == idx1_q) ? min2_q : min1_q;

`ifdef CNU_OFFSET_EN
   localparam logic [MW-1:0] OFFV = MW'(OFFSET);
   assign mag_off = (mag_sel > OFFV) ? (mag_sel - OFFV) : '0;
`else
   assign mag_off = mag_sel;
`endif

   assign mag_sat = (mag_off > SATV) ? SATV[OW-2:0] : mag_off[OW-2:0];

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == EMIT);
   assign out_msg   = out_valid ? {sx_q ^ sign_q[cnt_q], mag_sat} : '0;
   assign out_idx   = out_valid ? cnt_q : '0;
   assign out_last  = out_valid && (cnt_q == LAST);
   assign p_bit     = pbit_q;

endmodule

// File: tb/tb_cnu_serial.sv
// Scoreboard bench for cnu_serial (DC=6, W=6, OW=5).
// Expected tables switch with CNU_OFFSET_EN.
module tb_cnu_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_msg;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_msg;
   logic [2:0] out_idx;
   logic       out_last;
   logic       p_bit;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] msg;
      logic [2:0] idx;
      logic       last;
      logic       pb;
   } exp_t;

   exp_t sb[$];

   cnu_serial #(.DC(6), .W(6), .OW(5), .OFFSET(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_msg    (in_msg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_msg   (out_msg),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .p_bit     (p_bit)
   );

   always #5 clk = ~clk;

   localparam logic [0:5][5:0] IN_A = {6'b110101, 6'b001010, 6'b111001,
                                       6'b111100, 6'b000011, 6'b111111};
   localparam logic [0:5][5:0] IN_T = {6{6'b000101}};
   localparam logic [0:5][5:0] IN_S = {6'd31, 6'd30, 6'd29,
                                       6'd28, 6'd27, 6'd20};
   localparam logic [0:5][5:0] IN_P = {6'b100001, 6'b000010, 6'b000011,
                                       6'b000100, 6'b000101, 6'b000110};

`ifdef CNU_OFFSET_EN
   localparam logic [0:5][4:0] EX_A = {5'b10010, 5'b00010, 5'b10010,
                                       5'b10010, 5'b01001, 5'b10010};
   localparam logic [0:5][4:0] EX_T = {6{5'b00100}};
   localparam logic [0:5][4:0] EX_P = {5'b00001, {5{5'b10000}}};
`else
   localparam logic [0:5][4:0] EX_A = {5'b10011, 5'b00011, 5'b10011,
                                       5'b10011, 5'b01010, 5'b10011};
   localparam logic [0:5][4:0] EX_T = {6{5'b00101}};
   localparam logic [0:5][4:0] EX_P = {5'b00010, {5{5'b10001}}};
`endif
   localparam logic [0:5][4:0] EX_S = {6{5'b01111}};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops one expectation per output handshake
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {24'd0, out_msg, out_idx}, 32'hFFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_beat", {22'd0, out_msg, out_idx, out_last, p_bit},
                {22'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [5:0] m);
      int n;
      n        = 0;
      in_msg   = m;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      chk("accept_wait", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_msg   = '0;
   endtask

   task automatic send_frame(input logic [0:5][5:0] m,
                             input logic [0:5][4:0] e,
                             input logic pb, input bit gap);
      for (int i = 0; i < 6; i++) begin
         exp_t x;
         x.msg  = e[i];
         x.idx  = 3'(i);
         x.last = (i == 5);
         x.pb   = pb;
         sb.push_back(x);
      end
      for (int i = 0; i < 6; i++) begin
         send(m[i]);
         if (gap) tick();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 500) begin
         tick();
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      logic [4:0] held;
      int         n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_msg    = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_msg",   {27'd0, out_msg},   32'd0);
      chk("rst_out_idx",   {29'd0, out_idx},   32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_p_bit",     {31'd0, p_bit},     32'd0);
      rst_n = 1'b1;
      tick();

      send_frame(IN_A, EX_A, 1'b0, 1'b0);
      drain();
      send_frame(IN_T, EX_T, 1'b0, 1'b1);
      drain();
      send_frame(IN_S, EX_S, 1'b0, 1'b0);
      drain();

      // backpressure: stall on index 2 while pulsing in_valid
      out_ready = 1'b0;
      send_frame(IN_A, EX_A, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      tick();
      tick();
      chk("bp_idx2", {29'd0, out_idx}, 32'd2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_msg    = 6'b000000;
      held      = out_msg;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_msg_hold", {27'd0, out_msg},  {27'd0, held});
         chk("bp_idx_hold", {29'd0, out_idx},  32'd2);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      send_frame(IN_P, EX_P, 1'b1, 1'b0);
      drain();
      chk("pbit_hold_collect", {31'd0, p_bit}, 32'd1);

      // partial frame then asynchronous reset
      send(6'b000001);
      send(6'b000001);
      send(6'b000001);
      chk("pbit_before_rst", {31'd0, p_bit}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_p_bit",  {31'd0, p_bit},    32'd0);
      chk("async_rst_ready",  {31'd0, in_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      send_frame(IN_A, EX_A, 1'b0, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
